// File: rtl/i2s_pkg.sv
// Shared I2S timebase constants and sample-pair type for the codec TX/RX paths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2s_pkg;

    localparam int FRM_CNT_W    = 10;  // one frame = 1024 system clocks
    localparam int SCLK_DIV_BIT = 3;   // SCLK = clk/16
    localparam int MCLK_DIV_BIT = 1;   // MCLK = clk/4
    localparam int LR_DIV_BIT   = 9;   // LRCLK = clk/1024
    localparam int SLOTS_PER_CH = 32;  // SCLK periods per channel half-frame

    // Width of the per-channel slot index carved out of the frame counter.
    localparam int SLOT_W = LR_DIV_BIT - SCLK_DIV_BIT - 1;

    // Sample pairs are carried at the widest legal sample width; narrower
    // samples occupy the low bits and the upper bits stay zero.
    localparam int SMPL_MAX_W = 32;

    typedef struct packed {
        logic [SMPL_MAX_W-1:0] lft;
        logic [SMPL_MAX_W-1:0] rht;
    } smpl_pair_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S timebase: free-running frame counter with MCLK/SCLK/LRCLK and slot strobes.
// Latency: clocks are direct flop outputs; strobes decode the current count.
// Backpressure: none, free-running; shared by the TX serializer and RX deserializer.
module i2s_clk_gen
    import i2s_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    output logic              mclk_o,
    output logic              sclk_o,
    output logic              lrclk_o,
    output logic              sclk_fall_o,   // next edge drives SCLK low
    output logic              frame_end_o,   // next edge starts a new frame
    output logic [SLOT_W-1:0] slot_nxt_o,    // slot index after the next edge
    output logic              ch_nxt_o       // channel after the next edge, 0 = left
);

    logic [FRM_CNT_W-1:0] cnt_q;
    logic [FRM_CNT_W-1:0] cnt_d;

    // Next count: plain binary increment, wraps naturally at the frame end.
    always_comb begin
        cnt_d = cnt_q + FRM_CNT_W'(1);
    end

    // Frame counter register; every derived clock is a bit of this flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign mclk_o      = cnt_q[MCLK_DIV_BIT];
    assign sclk_o      = cnt_q[SCLK_DIV_BIT];
    assign lrclk_o     = cnt_q[LR_DIV_BIT];
    assign sclk_fall_o = &cnt_q[SCLK_DIV_BIT:0];
    assign frame_end_o = &cnt_q;
    assign slot_nxt_o  = cnt_d[LR_DIV_BIT-1:SCLK_DIV_BIT+1];
    assign ch_nxt_o    = cnt_d[LR_DIV_BIT];

endmodule

// File: rtl/i2s_tx_serf.sv
// I2S transmitter: buffers one L/R pair and shifts it MSB-first onto SDin each frame.
// Latency: an accepted pair goes out in the frame after the next frame boundary.
// Backpressure: rdy low while the one-entry buffer holds a pair; frees at frame end.
module i2s_tx_serf
    import i2s_pkg::*;
#(
    parameter int SMPL_W = 24,
    parameter int UCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SMPL_W-1:0] lft_in,
    input  logic [SMPL_W-1:0] rht_in,
    input  logic              vld,
    output logic              rdy,
    output logic              MCLK,
    output logic              SCLK,
    output logic              LRCLK,
    output logic              SDin,
    output logic              frm_strt,
    output logic [UCNT_W-1:0] underrun
);

    localparam int PAD_W = SMPL_MAX_W - SMPL_W;

    logic              sclk_fall;
    logic              frame_end;
    logic [SLOT_W-1:0] slot_nxt;
    logic              ch_nxt;

    smpl_pair_t        buf_q, buf_d;
    logic              buf_full_q, buf_full_d;
    smpl_pair_t        tx_q, tx_d;
    logic [UCNT_W-1:0] urun_q, urun_d;
    logic              sdin_q, sdin_d;

    logic                  accept;
    logic [SMPL_MAX_W-1:0] word;
    logic [SLOT_W-1:0]     bidx;

    i2s_clk_gen u_clk_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .mclk_o      (MCLK),
        .sclk_o      (SCLK),
        .lrclk_o     (LRCLK),
        .sclk_fall_o (sclk_fall),
        .frame_end_o (frame_end),
        .slot_nxt_o  (slot_nxt),
        .ch_nxt_o    (ch_nxt)
    );

    assign rdy    = !buf_full_q;
    assign accept = vld && rdy;

    // Buffer, transmit pair and underrun counter. The frame load sees the
    // buffer as it was before any same-cycle accept: a full buffer blocks the
    // accept, an empty one both counts an underrun and takes the new pair.
    always_comb begin
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        tx_d       = tx_q;
        urun_d     = urun_q;
        if (frame_end) begin
            if (buf_full_q) begin
                tx_d       = buf_q;
                buf_full_d = 1'b0;
            end else if (!(&urun_q)) begin
                urun_d = urun_q + UCNT_W'(1);
            end
        end
        if (accept) begin
            buf_d.lft  = {{PAD_W{1'b0}}, lft_in};
            buf_d.rht  = {{PAD_W{1'b0}}, rht_in};
            buf_full_d = 1'b1;
        end
    end

    // Serial data for the upcoming slot, committed on the edge that drops
    // SCLK. Slot 0 is the one-bit I2S delay; slots past the sample are zero.
    always_comb begin
        sdin_d = sdin_q;
        word   = ch_nxt ? tx_q.rht : tx_q.lft;
        bidx   = SLOT_W'(SMPL_W) - slot_nxt;
        if (sclk_fall) begin
            if ((slot_nxt != '0) && (int'(slot_nxt) <= SMPL_W)) begin
                sdin_d = word[bidx];
            end else begin
                sdin_d = 1'b0;
            end
        end
    end

    // Datapath state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            tx_q       <= '0;
            urun_q     <= '0;
            sdin_q     <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            tx_q       <= tx_d;
            urun_q     <= urun_d;
            sdin_q     <= sdin_d;
        end
    end

    assign SDin     = sdin_q;
    assign frm_strt = frame_end;
    assign underrun = urun_q;

endmodule

// File: tb/tb_i2s_tx_serf.sv
// Directed bench for the I2S transmitter: clocks, framing, handshake, underrun, reset.
// Latency: frames are captured at SCLK rising and compared against expected bit vectors.
// Backpressure: the source holds data while rdy is low and advances only after an accept.
module tb_i2s_tx_serf;

    localparam int SW = 24;
    localparam int UW = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [SW-1:0] lft_in = '0;
    logic [SW-1:0] rht_in = '0;
    logic          vld    = 1'b0;
    logic          rdy;
    logic          MCLK, SCLK, LRCLK, SDin, frm_strt;
    logic [UW-1:0] underrun;

    int            n_vec = 0;
    int            n_err = 0;
    logic [UW-1:0] exp_urun;
    logic [9:0]    m_cnt;
    logic [SW-1:0] last_l, last_r;

    i2s_tx_serf #(.SMPL_W(SW), .UCNT_W(UW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .lft_in   (lft_in),
        .rht_in   (rht_in),
        .vld      (vld),
        .rdy      (rdy),
        .MCLK     (MCLK),
        .SCLK     (SCLK),
        .LRCLK    (LRCLK),
        .SDin     (SDin),
        .frm_strt (frm_strt),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    // Reference frame position: starts at 0 out of reset, +1 per clock.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_cnt <= '0;
        else        m_cnt <= m_cnt + 10'd1;
    end

    task automatic wait_cnt(input logic [9:0] tgt);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((m_cnt != tgt) && (n < 2048));
        if (m_cnt != tgt) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_cnt timeout got=%0d want=%0d", m_cnt, tgt);
        end
    endtask

    // Codec-side receiver: sample SDin at each SCLK rising edge of one frame.
    task automatic capture(output logic [63:0] cap);
        cap = '0;
        for (int k = 0; k < 64; k++) begin
            wait_cnt(10'(16 * k + 8));
            cap = {cap[62:0], SDin};
        end
    endtask

    task automatic sat_inc();
        if (exp_urun != {UW{1'b1}}) exp_urun = exp_urun + 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_vec++;
        if ({MCLK, SCLK, LRCLK} !== 3'b000) begin
            n_err++; $display("FAIL reset_clks got=%b want=000", {MCLK, SCLK, LRCLK});
        end
        n_vec++;
        if ({SDin, frm_strt} !== 2'b00) begin
            n_err++; $display("FAIL reset_sdin_frm got=%b want=00", {SDin, frm_strt});
        end
        n_vec++;
        if (rdy !== 1'b1) begin
            n_err++; $display("FAIL reset_rdy got=%b want=1", rdy);
        end
        n_vec++;
        if (underrun !== '0) begin
            n_err++; $display("FAIL reset_underrun got=%0d want=0", underrun);
        end
        rst_n    = 1'b1;
        exp_urun = '0;
    endtask

    task automatic test_idle_clocks();
        logic [UW-1:0] u;
        for (int i = 0; i < 2048; i++) begin
            u = (i < 1024) ? UW'(0) : UW'(1);
            n_vec++;
            if ({MCLK, SCLK, LRCLK, SDin, frm_strt, rdy, underrun} !==
                {m_cnt[1], m_cnt[3], m_cnt[9], 1'b0, (m_cnt == 10'd1023), 1'b1, u}) begin
                n_err++;
                $display("FAIL idle_clocks i=%0d got=%b want=%b", i,
                         {MCLK, SCLK, LRCLK, SDin, frm_strt, rdy, underrun},
                         {m_cnt[1], m_cnt[3], m_cnt[9], 1'b0, (m_cnt == 10'd1023), 1'b1, u});
            end
            @(negedge clk);
        end
        exp_urun = UW'(2);
        n_vec++;
        if (underrun !== exp_urun) begin
            n_err++; $display("FAIL idle_underrun got=%0d want=%0d", underrun, exp_urun);
        end
    endtask

    task automatic test_single_pair();
        logic [63:0] cap, expv;
        logic [SW-1:0] a_l, a_r;
        vld = 1'b1; lft_in = 24'hA50F3C; rht_in = 24'h800001;
        n_vec++;
        if (rdy !== 1'b1) begin n_err++; $display("FAIL single_rdy_pre got=%b want=1", rdy); end
        @(negedge clk);
        vld = 1'b0;
        n_vec++;
        if (rdy !== 1'b0) begin n_err++; $display("FAIL single_rdy_post got=%b want=0", rdy); end
        wait_cnt(10'd1023);
        n_vec++;
        if (frm_strt !== 1'b1) begin n_err++; $display("FAIL single_frm_strt got=%b want=1", frm_strt); end
        @(negedge clk);
        n_vec++;
        if (rdy !== 1'b1) begin n_err++; $display("FAIL single_rdy_reopen got=%b want=1", rdy); end
        capture(cap);
        expv = {1'b0, 24'hA50F3C, 7'b0, 1'b0, 24'h800001, 7'b0};
        n_vec++;
        if (cap !== expv) begin n_err++; $display("FAIL single_frame got=%h want=%h", cap, expv); end
        a_l = cap[62:39];
        a_r = cap[30:7];
        n_vec++;
        if (a_l !== 24'hA50F3C) begin n_err++; $display("FAIL single_aout_lft got=%h want=a50f3c", a_l); end
        n_vec++;
        if (a_r !== 24'h800001) begin n_err++; $display("FAIL single_aout_rht got=%h want=800001", a_r); end
        n_vec++;
        if ({cap[38:32], cap[6:0]} !== 14'b0) begin
            n_err++; $display("FAIL single_tail_slots got=%b want=0", {cap[38:32], cap[6:0]});
        end
        n_vec++;
        if (underrun !== exp_urun) begin n_err++; $display("FAIL single_underrun got=%0d want=%0d", underrun, exp_urun); end
    endtask

    task automatic test_back_to_back();
        int k, acc;
        logic pend;
        wait_cnt(10'd1023);
        @(negedge clk);
        sat_inc();
        n_vec++;
        if (underrun !== exp_urun) begin n_err++; $display("FAIL b2b_underrun_pre got=%0d want=%0d", underrun, exp_urun); end
        k = 0; acc = 0; pend = 1'b0;
        vld = 1'b1; lft_in = 24'h5A0000 | 24'(k); rht_in = 24'hC30000 | 24'(k);
        for (int i = 0; i < 3072; i++) begin
            if (pend) begin
                n_vec++;
                if (rdy !== 1'b0) begin n_err++; $display("FAIL b2b_rdy_drop i=%0d got=%b want=0", i, rdy); end
                k++;
                lft_in = 24'h5A0000 | 24'(k); rht_in = 24'hC30000 | 24'(k);
                pend = 1'b0;
            end
            if (m_cnt == 10'd0) begin
                n_vec++;
                if (rdy !== 1'b1) begin n_err++; $display("FAIL b2b_rdy_rise i=%0d got=%b want=1", i, rdy); end
            end
            if (vld && rdy) begin
                pend = 1'b1; acc++; last_l = lft_in; last_r = rht_in;
            end
            if (m_cnt == 10'd1023) begin
                n_vec++;
                if (acc != 1) begin n_err++; $display("FAIL b2b_accepts i=%0d got=%0d want=1", i, acc); end
                acc = 0;
            end
            @(negedge clk);
        end
        vld = 1'b0;
        n_vec++;
        if (underrun !== exp_urun) begin n_err++; $display("FAIL b2b_underrun got=%0d want=%0d", underrun, exp_urun); end
    endtask

    task automatic test_edge_accept();
        logic [63:0] cap, expv;
        wait_cnt(10'd1023);
        n_vec++;
        if ({rdy, frm_strt} !== 2'b11) begin n_err++; $display("FAIL edge_pre got=%b want=11", {rdy, frm_strt}); end
        vld = 1'b1; lft_in = 24'h3CC35A; rht_in = 24'h7FFFFF;
        @(negedge clk);
        vld = 1'b0;
        sat_inc();
        n_vec++;
        if (underrun !== exp_urun) begin n_err++; $display("FAIL edge_underrun got=%0d want=%0d", underrun, exp_urun); end
        n_vec++;
        if (rdy !== 1'b0) begin n_err++; $display("FAIL edge_rdy got=%b want=0", rdy); end
        capture(cap);
        expv = {1'b0, last_l, 7'b0, 1'b0, last_r, 7'b0};
        n_vec++;
        if (cap !== expv) begin n_err++; $display("FAIL edge_repeat_frame got=%h want=%h", cap, expv); end
        wait_cnt(10'd1023);
        @(negedge clk);
        n_vec++;
        if (underrun !== exp_urun) begin n_err++; $display("FAIL edge_underrun2 got=%0d want=%0d", underrun, exp_urun); end
        capture(cap);
        expv = {1'b0, 24'h3CC35A, 7'b0, 1'b0, 24'h7FFFFF, 7'b0};
        n_vec++;
        if (cap !== expv) begin n_err++; $display("FAIL edge_new_frame got=%h want=%h", cap, expv); end
    endtask

    task automatic test_starve();
        logic [63:0] cap, expv;
        for (int f = 0; f < 14; f++) begin
            wait_cnt(10'd1023);
            @(negedge clk);
            sat_inc();
            n_vec++;
            if (underrun !== exp_urun) begin
                n_err++; $display("FAIL starve_underrun f=%0d got=%0d want=%0d", f, underrun, exp_urun);
            end
        end
        n_vec++;
        if (underrun !== {UW{1'b1}}) begin n_err++; $display("FAIL starve_saturated got=%0d want=%0d", underrun, {UW{1'b1}}); end
        capture(cap);
        expv = {1'b0, 24'h3CC35A, 7'b0, 1'b0, 24'h7FFFFF, 7'b0};
        n_vec++;
        if (cap !== expv) begin n_err++; $display("FAIL starve_repeat got=%h want=%h", cap, expv); end
    endtask

    task automatic test_mid_reset();
        logic [63:0] cap;
        wait_cnt(10'd1023);
        @(negedge clk);
        vld = 1'b1; lft_in = 24'h654321; rht_in = 24'h0F0F0F;
        @(negedge clk);
        vld = 1'b0;
        n_vec++;
        if (rdy !== 1'b0) begin n_err++; $display("FAIL rst_buf_full got=%b want=0", rdy); end
        wait_cnt(10'd700);
        n_vec++;
        if ({LRCLK, SCLK} !== 2'b11) begin n_err++; $display("FAIL rst_pre_right got=%b want=11", {LRCLK, SCLK}); end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({MCLK, SCLK, LRCLK, SDin, frm_strt} !== 5'b0) begin
            n_err++; $display("FAIL rst_outs got=%b want=00000", {MCLK, SCLK, LRCLK, SDin, frm_strt});
        end
        n_vec++;
        if (rdy !== 1'b1) begin n_err++; $display("FAIL rst_rdy got=%b want=1", rdy); end
        n_vec++;
        if (underrun !== '0) begin n_err++; $display("FAIL rst_underrun got=%0d want=0", underrun); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_urun = '0;
        capture(cap);
        n_vec++;
        if (cap !== 64'h0) begin n_err++; $display("FAIL rst_first_frame got=%h want=0", cap); end
        wait_cnt(10'd1023);
        @(negedge clk);
        sat_inc();
        n_vec++;
        if (underrun !== exp_urun) begin n_err++; $display("FAIL rst_underrun_after got=%0d want=%0d", underrun, exp_urun); end
        n_vec++;
        if (rdy !== 1'b1) begin n_err++; $display("FAIL rst_rdy_after got=%b want=1", rdy); end
    endtask

    initial begin
        test_reset();
        test_idle_clocks();
        test_single_pair();
        test_back_to_back();
        test_edge_accept();
        test_starve();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
